// File: rtl/prog_pkg.sv
`default_nettype none
// prog_pkg - shared types and constants for the program loader | rev 1.0
package prog_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int INSTR_W        = 32;
   localparam int IDX_W          = $clog2(BYTES_PER_WORD);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ASSEMBLE = 2'd1,
      ST_WRITE    = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_word_packer.sv
`default_nettype none
// prog_word_packer - little-endian byte-lane packer; o_full marks the lane that completes a word | rev 1.0
module prog_word_packer
   import prog_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clr,
   input  logic               i_load,
   input  logic [IDX_W-1:0]   i_idx,
   input  logic [7:0]         i_byte,
   output logic [INSTR_W-1:0] o_word,
   output logic               o_full
);

   logic [INSTR_W-1:0] r_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
      end else if (i_clr) begin
         r_word <= '0;
      end else if (i_load) begin
         r_word[{i_idx, 3'b000} +: 8] <= i_byte;
      end
   end

   assign o_word = r_word;
   assign o_full = (i_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// prog_loader - assembles UART bytes into instruction words and writes them to memory | rev 1.0
// Optional build macro PROG_LOADER_CHECKSUM_EN adds checksum[7:0] (XOR of accepted bytes).
module prog_loader
   import prog_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               rx_dv,
   input  logic [7:0]         rx_byte,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wdata,
   input  logic               mem_ready,
   output logic [ADDR_W:0]    word_count,
   output logic               busy,
`ifdef PROG_LOADER_CHECKSUM_EN
   output logic [7:0]         checksum,
`endif
   output logic               overflow
);

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [7:0]         r_skid, w_skid_nxt;
   logic               r_skid_vld, w_skid_vld_nxt;
   logic [ADDR_W:0]    r_count, w_count_nxt;
   logic               r_ovf, w_ovf_nxt;
   logic               w_pk_load, w_pk_clr, w_pk_last;
   logic [7:0]         w_pk_byte;
   logic [INSTR_W-1:0] w_word;
   logic               w_mem_full;

   assign w_mem_full = r_count[ADDR_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_skid     <= '0;
         r_skid_vld <= 1'b0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_skid     <= w_skid_nxt;
         r_skid_vld <= w_skid_vld_nxt;
         r_count    <= w_count_nxt;
         r_ovf      <= w_ovf_nxt;
      end
   end

   // r_idx is zero in IDLE and WRITE, so the packer lane always follows r_idx.
   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_skid_nxt     = r_skid;
      w_skid_vld_nxt = r_skid_vld;
      w_count_nxt    = r_count;
      w_ovf_nxt      = r_ovf;
      w_pk_load      = 1'b0;
      w_pk_clr       = 1'b0;
      w_pk_byte      = rx_byte;

      if (start) begin
         w_state_nxt    = ST_IDLE;
         w_idx_nxt      = '0;
         w_skid_nxt     = '0;
         w_skid_vld_nxt = 1'b0;
         w_count_nxt    = '0;
         w_ovf_nxt      = 1'b0;
         w_pk_clr       = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (rx_dv) begin
                  w_pk_load   = 1'b1;
                  w_idx_nxt   = IDX_W'(1);
                  w_state_nxt = ST_ASSEMBLE;
               end
            end
            ST_ASSEMBLE: begin
               if (rx_dv) begin
                  w_pk_load = 1'b1;
                  if (w_pk_last) begin
                     w_idx_nxt = '0;
                     if (w_mem_full) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                     end else begin
                        w_state_nxt = ST_WRITE;
                     end
                  end else begin
                     w_idx_nxt = r_idx + IDX_W'(1);
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ready) begin
                  w_count_nxt = r_count + (ADDR_W + 1)'(1);
                  if (r_skid_vld) begin
                     w_pk_load      = 1'b1;
                     w_pk_byte      = r_skid;
                     w_skid_vld_nxt = 1'b0;
                     w_idx_nxt      = IDX_W'(1);
                     w_state_nxt    = ST_ASSEMBLE;
                     if (rx_dv) w_ovf_nxt = 1'b1;
                  end else if (rx_dv) begin
                     // Byte on the handshake cycle bypasses the skid straight into lane 0.
                     w_pk_load   = 1'b1;
                     w_idx_nxt   = IDX_W'(1);
                     w_state_nxt = ST_ASSEMBLE;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else if (rx_dv) begin
                  if (r_skid_vld) begin
                     w_ovf_nxt = 1'b1;
                  end else begin
                     w_skid_nxt     = rx_byte;
                     w_skid_vld_nxt = 1'b1;
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   prog_word_packer u_packer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_pk_clr),
      .i_load (w_pk_load),
      .i_idx  (r_idx),
      .i_byte (w_pk_byte),
      .o_word (w_word),
      .o_full (w_pk_last)
   );

   assign mem_we     = (r_state == ST_WRITE);
   assign mem_addr   = r_count[ADDR_W-1:0];
   assign mem_wdata  = w_word;
   assign word_count = r_count;
   assign busy       = (r_state != ST_IDLE);
   assign overflow   = r_ovf;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] r_chk;
   logic       w_accept;

   assign w_accept = rx_dv & ~start & ~((r_state == ST_WRITE) & r_skid_vld);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chk <= '0;
      end else if (start) begin
         r_chk <= '0;
      end else if (w_accept) begin
         r_chk <= r_chk ^ rx_byte;
      end
   end

   assign checksum = r_chk;
`endif

endmodule
`default_nettype wire
